// File: rtl/ariane_soc.sv
// SoC-wide peripheral map: slave indices, base/length constants and the rule table
// walked by the peripheral arbiter's address decoder, plus the arbiter FSM state type.
package ariane_soc;

    typedef enum int unsigned {
        DRAM     = 0,
        GPIO     = 1,
        Ethernet = 2,
        SPI      = 3,
        Timer    = 4,
        UART     = 5,
        PLIC     = 6,
        CLINT    = 7,
        ROM      = 8,
        Debug    = 9
    } axi_slaves_t;

    localparam int NB_PERIPHERALS = int'(Debug) + 1;

    localparam logic [63:0] DebugLength    = 64'h1000;
    localparam logic [63:0] ROMLength      = 64'h10000;
    localparam logic [63:0] CLINTLength    = 64'hC0000;
    localparam logic [63:0] PLICLength     = 64'h3FF_FFFF;
    localparam logic [63:0] UARTLength     = 64'h1000;
    localparam logic [63:0] TimerLength    = 64'h1000;
    localparam logic [63:0] SPILength      = 64'h80_0000;
    localparam logic [63:0] EthernetLength = 64'h1_0000;
    localparam logic [63:0] GPIOLength     = 64'h1000;
    localparam logic [63:0] DRAMLength     = 64'h4000_0000;

    localparam logic [63:0] DebugBase    = 64'h0000_0000;
    localparam logic [63:0] ROMBase      = 64'h0001_0000;
    localparam logic [63:0] CLINTBase    = 64'h0200_0000;
    localparam logic [63:0] PLICBase     = 64'h0C00_0000;
    localparam logic [63:0] UARTBase     = 64'h1000_0000;
    localparam logic [63:0] TimerBase    = 64'h1800_0000;
    localparam logic [63:0] SPIBase      = 64'h2000_0000;
    localparam logic [63:0] EthernetBase = 64'h3000_0000;
    localparam logic [63:0] GPIOBase     = 64'h4000_0000;
    localparam logic [63:0] DRAMBase     = 64'h8000_0000;

    typedef struct packed {
        axi_slaves_t idx;
        logic [63:0] base;
        logic [63:0] length;
    } periph_rule_t;

    // Entry i describes slave i, so the decoder can use the loop index as the select bit.
    localparam periph_rule_t PeriphMap [NB_PERIPHERALS] = '{
        '{idx: DRAM,     base: DRAMBase,     length: DRAMLength},
        '{idx: GPIO,     base: GPIOBase,     length: GPIOLength},
        '{idx: Ethernet, base: EthernetBase, length: EthernetLength},
        '{idx: SPI,      base: SPIBase,      length: SPILength},
        '{idx: Timer,    base: TimerBase,    length: TimerLength},
        '{idx: UART,     base: UARTBase,     length: UARTLength},
        '{idx: PLIC,     base: PLICBase,     length: PLICLength},
        '{idx: CLINT,    base: CLINTBase,    length: CLINTLength},
        '{idx: ROM,      base: ROMBase,      length: ROMLength},
        '{idx: Debug,    base: DebugBase,    length: DebugLength}
    };

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RSP  = 2'd2,
        ERR  = 2'd3
    } arb_state_t;

endpackage

// File: rtl/periph_rr_arbiter.sv
// N-way round-robin picker: combinational one-hot grant and index, search starting at
// the pointer; the pointer moves past the winner only when advance_i is strobed.
module periph_rr_arbiter #(
    parameter int N    = 3,
    parameter int IdxW = (N > 1) ? $clog2(N) : 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [N-1:0]    req_i,
    input  logic            advance_i,
    output logic [N-1:0]    gnt_o,
    output logic [IdxW-1:0] idx_o
);

    logic [IdxW-1:0] ptr;

    always_comb begin
        int pos;
        logic found;
        logic [IdxW-1:0] cand;
        pos   = 0;
        found = 1'b0;
        cand  = '0;
        gnt_o = '0;
        idx_o = '0;
        for (int k = 0; k < N; k++) begin
            pos = int'(ptr) + k;
            if (pos >= N) pos = pos - N;
            cand = IdxW'(pos);
            if (!found && req_i[cand]) begin
                found       = 1'b1;
                gnt_o[cand] = 1'b1;
                idx_o       = cand;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr <= '0;
        end else if (advance_i) begin
            ptr <= (idx_o == IdxW'(N - 1)) ? '0 : idx_o + 1'b1;
        end
    end

endmodule

// File: rtl/soc_periph_arbiter.sv
// Shares the peripheral register port among all masters: round-robin grant in IDLE,
// address decode against PeriphMap, one transaction in flight, error on miss or timeout.
module soc_periph_arbiter
    import ariane_soc::*;
#(
    parameter int NumMasters    = 3,
    parameter int AddrWidth     = 64,
    parameter int DataWidth     = 64,
    parameter int TimeoutCycles = 1024
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic [NumMasters-1:0]                 req_i,
    input  logic [NumMasters*AddrWidth-1:0]       addr_i,
    input  logic [NumMasters-1:0]                 we_i,
    input  logic [NumMasters*DataWidth-1:0]       wdata_i,
    input  logic [NumMasters*(DataWidth/8)-1:0]   be_i,
    output logic [NumMasters-1:0]                 gnt_o,
    output logic [NumMasters-1:0]                 rvalid_o,
    output logic [DataWidth-1:0]                  rdata_o,
    output logic                                  err_o,
    output logic                                  slv_req_o,
    output logic [NB_PERIPHERALS-1:0]             slv_sel_o,
    output logic [AddrWidth-1:0]                  slv_addr_o,
    output logic                                  slv_we_o,
    output logic [DataWidth-1:0]                  slv_wdata_o,
    output logic [DataWidth/8-1:0]                slv_be_o,
    input  logic                                  slv_gnt_i,
    input  logic                                  slv_rvalid_i,
    input  logic [DataWidth-1:0]                  slv_rdata_i,
    input  logic                                  slv_err_i
);

    localparam int IdxW = (NumMasters > 1) ? $clog2(NumMasters) : 1;
    localparam int CntW = $clog2(TimeoutCycles + 1);
    localparam int BeW  = DataWidth / 8;

    arb_state_t state_q, state_d;

    logic [NumMasters-1:0]     arb_gnt;
    logic [IdxW-1:0]           arb_idx;
    logic                      grant;
    logic [IdxW-1:0]           win_q;
    logic [CntW-1:0]           cnt_q;
    logic                      timeout;
    logic                      rsp_take;
    logic                      err_rsp;

    logic [AddrWidth-1:0]      win_addr;
    logic [63:0]               addr_ext;
    logic [63:0]               dec_base;
    logic [63:0]               dec_off;
    logic                      dec_hit;
    logic [NB_PERIPHERALS-1:0] dec_sel;

    periph_rr_arbiter #(
        .N    (NumMasters),
        .IdxW (IdxW)
    ) u_rr (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .req_i     (req_i),
        .advance_i (grant),
        .gnt_o     (arb_gnt),
        .idx_o     (arb_idx)
    );

    // Grants only while idle; held low during reset so nothing looks granted.
    assign grant = (state_q == IDLE) && (|req_i) && !rst_i;
    assign gnt_o = grant ? arb_gnt : '0;

    assign win_addr = addr_i[arb_idx*AddrWidth +: AddrWidth];
    assign addr_ext = 64'(win_addr);

    // Comparing the offset against length avoids forming base+length.
    always_comb begin
        dec_hit  = 1'b0;
        dec_sel  = '0;
        dec_base = '0;
        for (int i = 0; i < NB_PERIPHERALS; i++) begin
            if (addr_ext >= PeriphMap[i].base &&
                (addr_ext - PeriphMap[i].base) < PeriphMap[i].length) begin
                dec_hit    = 1'b1;
                dec_sel[i] = 1'b1;
                dec_base   = PeriphMap[i].base;
            end
        end
    end

    assign dec_off = addr_ext - dec_base;

    assign timeout   = ((state_q == REQ) || (state_q == RSP)) &&
                       (cnt_q == CntW'(TimeoutCycles - 1));
    assign slv_req_o = (state_q == REQ);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        rsp_take = 1'b0;
        err_rsp  = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant) state_d = dec_hit ? REQ : ERR;
            end
            REQ: begin
                if (slv_gnt_i && slv_rvalid_i) begin
                    rsp_take = 1'b1;
                    state_d  = IDLE;
                end else if (timeout) begin
                    err_rsp = 1'b1;
                    state_d = IDLE;
                end else if (slv_gnt_i) begin
                    state_d = RSP;
                end
            end
            RSP: begin
                if (slv_rvalid_i) begin
                    rsp_take = 1'b1;
                    state_d  = IDLE;
                end else if (timeout) begin
                    err_rsp = 1'b1;
                    state_d = IDLE;
                end
            end
            ERR: begin
                err_rsp = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            win_q       <= '0;
            cnt_q       <= '0;
            slv_sel_o   <= '0;
            slv_addr_o  <= '0;
            slv_we_o    <= 1'b0;
            slv_wdata_o <= '0;
            slv_be_o    <= '0;
            rvalid_o    <= '0;
            rdata_o     <= '0;
            err_o       <= 1'b0;
        end else begin
            rvalid_o <= '0;
            if (grant) begin
                win_q       <= arb_idx;
                cnt_q       <= '0;
                slv_sel_o   <= dec_hit ? dec_sel : '0;
                slv_addr_o  <= dec_hit ? AddrWidth'(dec_off) : '0;
                slv_we_o    <= we_i[arb_idx];
                slv_wdata_o <= wdata_i[arb_idx*DataWidth +: DataWidth];
                slv_be_o    <= be_i[arb_idx*BeW +: BeW];
            end else if ((state_q == REQ) || (state_q == RSP)) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (rsp_take) begin
                rvalid_o <= NumMasters'(1) << win_q;
                rdata_o  <= slv_rdata_i;
                err_o    <= slv_err_i;
            end else if (err_rsp) begin
                rvalid_o <= NumMasters'(1) << win_q;
                rdata_o  <= '0;
                err_o    <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_soc_periph_arbiter.sv
// Directed bench for soc_periph_arbiter with three masters and a 16-cycle timeout.
module tb_soc_periph_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic [2:0]   req, we;
    logic [191:0] addr, wdata;
    logic [23:0]  be;
    logic [2:0]   gnt, rvalid;
    logic [63:0]  rdata;
    logic         err;
    logic         slv_req;
    logic [9:0]   slv_sel;
    logic [63:0]  slv_addr;
    logic         slv_we;
    logic [63:0]  slv_wdata;
    logic [7:0]   slv_be;
    logic         slv_gnt, slv_rvalid, slv_err;
    logic [63:0]  slv_rdata;

    int n_checks = 0;
    int n_pass   = 0;
    int req_cycles;

    always #5 clk = ~clk;

    soc_periph_arbiter #(
        .NumMasters    (3),
        .AddrWidth     (64),
        .DataWidth     (64),
        .TimeoutCycles (16)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req_i        (req),
        .addr_i       (addr),
        .we_i         (we),
        .wdata_i      (wdata),
        .be_i         (be),
        .gnt_o        (gnt),
        .rvalid_o     (rvalid),
        .rdata_o      (rdata),
        .err_o        (err),
        .slv_req_o    (slv_req),
        .slv_sel_o    (slv_sel),
        .slv_addr_o   (slv_addr),
        .slv_we_o     (slv_we),
        .slv_wdata_o  (slv_wdata),
        .slv_be_o     (slv_be),
        .slv_gnt_i    (slv_gnt),
        .slv_rvalid_i (slv_rvalid),
        .slv_rdata_i  (slv_rdata),
        .slv_err_i    (slv_err)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic drive_master(input int m, input logic [63:0] a, input logic w,
                                input logic [63:0] d, input logic [7:0] b);
        addr[m*64 +: 64] = a;
        we[m]            = w;
        wdata[m*64 +: 64] = d;
        be[m*8 +: 8]     = b;
    endtask

    task automatic check_all_zero(input string pfx);
        check({pfx, "_gnt"},    64'(gnt), 0);
        check({pfx, "_rvalid"}, 64'(rvalid), 0);
        check({pfx, "_rdata"},  rdata, 0);
        check({pfx, "_err"},    64'(err), 0);
        check({pfx, "_sreq"},   64'(slv_req), 0);
        check({pfx, "_ssel"},   64'(slv_sel), 0);
        check({pfx, "_saddr"},  slv_addr, 0);
        check({pfx, "_swe"},    64'(slv_we), 0);
        check({pfx, "_swdata"}, slv_wdata, 0);
        check({pfx, "_sbe"},    64'(slv_be), 0);
    endtask

    initial begin
        rst = 1'b1; req = '0; we = '0; addr = '0; wdata = '0; be = '0;
        slv_gnt = 0; slv_rvalid = 0; slv_err = 0; slv_rdata = '0;
        repeat (2) @(negedge clk);
        check_all_zero("rst");
        rst = 1'b0;

        // All three request continuously; slave answers in the grant cycle.
        @(negedge clk);
        for (int m = 0; m < 3; m++) drive_master(m, 64'h1000_0000, 1'b0, 0, 0);
        req = 3'b111; slv_gnt = 1; slv_rvalid = 1; slv_rdata = 64'h100;
        for (int i = 0; i < 6; i++) begin
            #1;
            check($sformatf("rr_gnt%0d", i), 64'(gnt), 64'(3'b001 << (i % 3)));
            if (i > 0) check($sformatf("rr_rv%0d", i), 64'(rvalid), 64'(3'b001 << ((i - 1) % 3)));
            @(negedge clk);
            if (i == 5) req = '0;
            @(negedge clk);
        end
        #1;
        check("rr_rv_last", 64'(rvalid), 64'(3'b100));
        check("rr_gnt_idle", 64'(gnt), 0);
        slv_gnt = 0; slv_rvalid = 0;

        // UART read from master 0, data one cycle after slave grant.
        @(negedge clk);
        drive_master(0, 64'h1000_0008, 1'b0, 0, 0);
        req = 3'b001; #1;
        check("uart_gnt", 64'(gnt), 64'(3'b001));
        @(negedge clk);
        check("uart_gnt_busy", 64'(gnt), 0);
        check("uart_sreq", 64'(slv_req), 1);
        check("uart_sel", 64'(slv_sel), 64'h20);
        check("uart_off", slv_addr, 64'h8);
        req = '0; slv_gnt = 1;
        @(negedge clk);
        check("uart_sreq_rsp", 64'(slv_req), 0);
        slv_gnt = 0; slv_rvalid = 1; slv_rdata = 64'hDEAD;
        @(negedge clk);
        slv_rvalid = 0;
        check("uart_rvalid", 64'(rvalid), 64'(3'b001));
        check("uart_rdata", rdata, 64'hDEAD);
        check("uart_err", 64'(err), 0);
        @(negedge clk);
        check("uart_pulse", 64'(rvalid), 0);

        // Best-case DRAM write at the top of DRAM from master 2.
        drive_master(2, 64'hBFFF_FFFF, 1'b1, 64'h1122_3344_5566_7788, 8'hF0);
        req = 3'b100; #1;
        check("dram_gnt", 64'(gnt), 64'(3'b100));
        @(negedge clk);
        req = '0;
        check("dram_sel", 64'(slv_sel), 64'h1);
        check("dram_off", slv_addr, 64'h3FFF_FFFF);
        check("dram_we", 64'(slv_we), 1);
        check("dram_wdata", slv_wdata, 64'h1122_3344_5566_7788);
        check("dram_be", 64'(slv_be), 64'hF0);
        slv_gnt = 1; slv_rvalid = 1; slv_rdata = 64'h1234;
        @(negedge clk);
        slv_gnt = 0; slv_rvalid = 0;
        check("dram_rvalid", 64'(rvalid), 64'(3'b100));
        check("dram_rdata", rdata, 64'h1234);

        // Unmapped write from master 1.
        @(negedge clk);
        drive_master(1, 64'h5000_0000, 1'b1, 64'h77, 8'hFF);
        req = 3'b010; #1;
        check("unmap_gnt", 64'(gnt), 64'(3'b010));
        @(negedge clk);
        req = '0;
        check("unmap_sreq", 64'(slv_req), 0);
        @(negedge clk);
        check("unmap_rvalid", 64'(rvalid), 64'(3'b010));
        check("unmap_err", 64'(err), 1);
        check("unmap_rdata", rdata, 0);

        // PLIC base, slave reports an error; pointer is at 2 so the search wraps to 0.
        @(negedge clk);
        drive_master(0, 64'h0C00_0000, 1'b0, 0, 0);
        req = 3'b001; #1;
        check("plic_gnt", 64'(gnt), 64'(3'b001));
        @(negedge clk);
        req = '0;
        check("plic_sel", 64'(slv_sel), 64'h40);
        check("plic_off", slv_addr, 0);
        slv_gnt = 1; slv_rvalid = 1; slv_rdata = 64'h77; slv_err = 1;
        @(negedge clk);
        slv_gnt = 0; slv_rvalid = 0; slv_err = 0;
        check("plic_rvalid", 64'(rvalid), 64'(3'b001));
        check("plic_err", 64'(err), 1);
        check("plic_rdata", rdata, 64'h77);

        // PLICBase + PLICLength is just past the PLIC window.
        @(negedge clk);
        drive_master(0, 64'h0FFF_FFFF, 1'b0, 0, 0);
        req = 3'b001; #1;
        @(negedge clk);
        req = '0;
        check("plicend_sreq", 64'(slv_req), 0);
        @(negedge clk);
        check("plicend_rvalid", 64'(rvalid), 64'(3'b001));
        check("plicend_err", 64'(err), 1);

        // Slave never grants: request drops after 16 cycles, late response ignored.
        @(negedge clk);
        drive_master(2, 64'h1000_0000, 1'b0, 0, 0);
        req = 3'b100; #1;
        check("to_gnt", 64'(gnt), 64'(3'b100));
        req_cycles = 0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (k == 0) req = '0;
            if (slv_req) req_cycles++;
        end
        @(negedge clk);
        check("to_req_cycles", 64'(req_cycles), 16);
        check("to_sreq_drop", 64'(slv_req), 0);
        check("to_rvalid", 64'(rvalid), 64'(3'b100));
        check("to_err", 64'(err), 1);
        check("to_rdata", rdata, 0);
        slv_rvalid = 1; slv_rdata = 64'hBAD;
        @(negedge clk);
        slv_rvalid = 0;
        @(negedge clk);
        check("to_late_rvalid", 64'(rvalid), 0);
        check("to_late_rdata", rdata, 0);

        // Reset while waiting in RSP; pointer was left at 2 by master 1's grant.
        drive_master(1, 64'h1000_0010, 1'b1, 64'hCAFE, 8'hFF);
        req = 3'b010; #1;
        check("rrst_gnt", 64'(gnt), 64'(3'b010));
        @(negedge clk);
        req = '0;
        check("rrst_we", 64'(slv_we), 1);
        slv_gnt = 1;
        @(negedge clk);
        slv_gnt = 0;
        rst = 1'b1; #1;
        check_all_zero("mid_rst");
        @(negedge clk);
        slv_rvalid = 1; slv_rdata = 64'h55;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        slv_rvalid = 0;
        check("rrst_no_rsp", 64'(rvalid), 0);
        drive_master(2, 64'h1000_0000, 1'b0, 0, 0);
        req = 3'b110; #1;
        check("rrst_lowest", 64'(gnt), 64'(3'b010));
        @(negedge clk);
        req = '0; slv_gnt = 1; slv_rvalid = 1; slv_rdata = 64'h42;
        @(negedge clk);
        slv_gnt = 0; slv_rvalid = 0;
        check("rrst_rvalid", 64'(rvalid), 64'(3'b010));
        check("rrst_rdata", rdata, 64'h42);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/soc_periph_arbiter.md
# soc_periph_arbiter

Shares the single peripheral register port between all bus masters: the harts plus the debug module, `NumHarts + 1` in total. It arbitrates round-robin between the masters. It decodes the winning address against the SoC peripheral map (Debug … DRAM bases and lengths) and forwards one transaction at a time to the selected peripheral. Unmapped accesses and peripherals that do not answer get an error response. It sits between the master-side request ports and the peripheral register interfaces of the SoC.

## Interface
- `NumMasters`, default 3: number of requesters (`NumHarts + 1`).
- `AddrWidth`, default 64: address width.
- `DataWidth`, default 64: data width.
- `TimeoutCycles`, default 1024: cycles allowed in REQ + RSP before an error response; must be ≥ 1.

Ports:
- `clk_i` input 1: single clock.
- `rst_i` input 1: reset, asynchronous, active-high.
- `req_i` input `NumMasters`: per-master request.
- `addr_i` input `NumMasters×AddrWidth`: per-master address.
- `we_i` input `NumMasters`: write enable.
- `wdata_i` input `NumMasters×DataWidth`: write data.
- `be_i` input `NumMasters×DataWidth/8`: byte enables.
- `gnt_o` output `NumMasters`: one-hot grant, combinational.
- `rvalid_o` output `NumMasters`: one-hot response valid, registered.
- `rdata_o` output `DataWidth`: response data, registered.
- `err_o` output 1: response error, qualified by `rvalid_o`.
- `slv_req_o` output 1: peripheral request.
- `slv_sel_o` output `NB_PERIPHERALS`: one-hot target, indexed by `axi_slaves_t`.
- `slv_addr_o` output `AddrWidth`: offset (`addr − base`).
- `slv_we_o`, `slv_wdata_o`, `slv_be_o`: registered copies of the granted master's fields.
- `slv_gnt_i` input 1: peripheral accepted the request.
- `slv_rvalid_i` input 1: peripheral response valid.
- `slv_rdata_i` input `DataWidth`: peripheral response data.
- `slv_err_i` input 1: peripheral error.

## Operation
- FSM states: IDLE, REQ, RSP, ERR. Reset state is IDLE.
- **IDLE**
  - If any `req_i` bit is set, the round-robin winner gets `gnt_o[w]=1` in that cycle.
  - The winner's fields are captured and the index `w` is latched.
  - The address is decoded: rule `i` hits when `base_i ≤ addr < base_i + length_i` (unsigned, 64-bit, no overflow because the map ends below 2^64). On a hit, `slv_sel_o` and offset are registered and the FSM goes to REQ. On a miss it goes to ERR.
- **REQ**
  - `slv_req_o=1` with stable fields until `slv_gnt_i=1`, then go to RSP.
  - `slv_gnt_i` and `slv_rvalid_i` may both be high in the same cycle: the response is taken immediately and the FSM returns to IDLE.
- **RSP**
  - `slv_req_o=0`. Wait for `slv_rvalid_i`.
  - On `slv_rvalid_i`: next cycle `rvalid_o[w]=1`, `rdata_o=slv_rdata_i`, `err_o=slv_err_i`. FSM returns to IDLE.
- **ERR**
  - Next cycle `rvalid_o[w]=1`, `err_o=1`, `rdata_o=0`. FSM returns to IDLE.
- **Round-robin**
  - The pointer is a register, reset 0.
  - On each grant, pointer ← (w+1) mod `NumMasters`.
  - The search starts at the pointer and wraps around.
- **Timeout**
  - A counter of width `$clog2(TimeoutCycles+1)` is cleared on grant and increments every cycle in REQ or RSP.
  - On reaching `TimeoutCycles`, drop `slv_req_o`, issue an ERR-style response, and go to IDLE.
  - `slv_rvalid_i` arriving in IDLE or ERR is discarded.
- Only one transaction is in flight. `gnt_o` is 0 outside IDLE.
- **Reset mid-transaction:** all state clears immediately and no response is issued.

## Timing
- Reset values: `gnt_o=0`, `rvalid_o=0`, `rdata_o=0`, `err_o=0`, `slv_req_o=0`, `slv_sel_o=0`, `slv_addr_o=0`, `slv_we_o=0`, `slv_wdata_o=0`, `slv_be_o=0`.
- Best-case mapped access: req/gnt at cycle 0, `slv_req_o` at cycle 1, `slv_gnt_i` and `slv_rvalid_i` at cycle 1, `rvalid_o` at cycle 2.
- Unmapped access: gnt at cycle 0, ERR at cycle 1, `rvalid_o`+`err_o` at cycle 2.
- `rvalid_o` is a single-cycle pulse. A new grant is possible in the cycle `rvalid_o` is high, because the FSM is already back in IDLE.
- Masters must hold `req_i` and their fields stable until granted.

## Structure
- In the `ariane_soc` package:
  - Add typedef `periph_rule_t` {`idx`, `base`, `length`}.
  - Add constant array `PeriphMap[NB_PERIPHERALS]` built from the existing Base/Length constants.
- Shared typedef for FSM state.
- One sub-module, `periph_rr_arbiter`: parameterised N-way round-robin with pointer register, `req` in, one-hot `gnt` and index out, `advance_i` strobe.
- Decode is a combinational loop over `PeriphMap` inside the top.

## Test plan
- Master 0 reads `0x1000_0008`; UART returns `0xDEAD` one cycle after `slv_gnt_i` → `slv_sel_o[UART]=1`, `slv_addr_o=0x8`, `rvalid_o=3'b001`, `rdata_o=0xDEAD`, `err_o=0`.
- All three masters request continuously → grants in order 0,1,2,0,1,2; no master starves; the pointer wraps.
- Master 1 writes `0x5000_0000` (unmapped) → no `slv_req_o`, `rvalid_o=3'b010` and `err_o=1` two cycles after grant.
- The peripheral never asserts `slv_gnt_i`, with `TimeoutCycles=16` → `slv_req_o` drops after 16 cycles, an error response goes to the requester, and a later `slv_rvalid_i` is ignored.
- Boundary addresses: `0x0C00_0000` → PLIC, offset 0; `0x0FFF_FFFF` (PLICBase + PLICLength) → error; `0x8000_0000+0x3FFF_FFFF` → DRAM.
- Assert `rst_i` in RSP → all outputs read 0 the same cycle; after release, the pointer is 0 and the next grant goes to the lowest requester.
